reflet_shift_io_expander: RTL

REFLET_SHIFT_IO_EXPANDER -- requirements
Module: reflet_shift_io_expander

---
 rtl/reflet_shift_io_pkg.sv | 18 +
 rtl/reflet_shift_io_divider.sv | 32 +++
 rtl/reflet_shift_io_expander.sv | 146 ++++++++++++++
 3 files changed

// File: rtl/reflet_shift_io_pkg.sv
// Shared definitions for the serial shift-register I/O expander:
// FSM state encoding and the frame-length formula.
package reflet_shift_io_pkg;

    typedef enum logic [2:0] {
        IDLE     = 3'd0,
        LOAD     = 3'd1,
        SHIFT_LO = 3'd2,
        SHIFT_HI = 3'd3,
        LATCH    = 3'd4
    } state_t;

    // One LOAD phase, two phases per bit, one LATCH phase; each phase is clk_div cycles.
    function automatic int frame_cycles(input int n, input int clk_div);
        return clk_div * (2 * n + 2);
    endfunction

endpackage

// File: rtl/reflet_shift_io_divider.sv
// Half-period tick generator: tick is high on the last cycle of every
// CLK_DIV-cycle phase. restart realigns the phase to the current state.
module reflet_shift_io_divider
    import reflet_shift_io_pkg::*;
#(
    parameter int CLK_DIV = 4
) (
    input  logic clk,
    input  logic reset,
    input  logic restart,
    output logic tick
);

    localparam int CW = (CLK_DIV > 1) ? $clog2(CLK_DIV) : 1;
    localparam logic [CW-1:0] LAST = CW'(CLK_DIV - 1);

    logic [CW-1:0] cnt;

    // Phase counter, cleared on every state change and on terminal count
    always_ff @(posedge clk) begin
        if (reset || restart) begin
            cnt <= '0;
        end else if (cnt == LAST) begin
            cnt <= '0;
        end else begin
            cnt <= cnt + 1'b1;
        end
    end

    assign tick = (cnt == LAST);

endmodule

// File: rtl/reflet_shift_io_expander.sv
// Continuous refresh engine for a 595-style output chain and a 165-style
// input chain sharing one shift clock. Each frame snapshots gpo_in, shifts
// it out MSB first while shifting the input chain in, then latches both.
//
// state    | meaning
// ---------+------------------------------------------------------------
// IDLE     | not refreshing; waits for enable
// LOAD     | input chain parallel load (sr_load_n low), gpo_in snapshot
// SHIFT_LO | shift clock low, current MSB on sr_dout, sr_din sampled last cycle
// SHIFT_HI | shift clock high; both shift registers advance on exit
// LATCH    | output storage latch pulse, gpi_out updated on entry
module reflet_shift_io_expander #(
    parameter int NUMBER_OF_IO = 16,
    parameter int CLK_DIV      = 4
) (
    input  logic                    clk,
    input  logic                    reset,
    input  logic                    enable,
    input  logic [NUMBER_OF_IO-1:0] gpo_in,
    output logic [NUMBER_OF_IO-1:0] gpi_out,
    output logic                    sr_dout,
    input  logic                    sr_din,
    output logic                    sr_clk,
    output logic                    sr_latch,
    output logic                    sr_load_n,
    output logic                    busy,
    output logic                    refresh_done
);

    import reflet_shift_io_pkg::*;

    localparam int N  = NUMBER_OF_IO;
    localparam int BW = (N > 1) ? $clog2(N) : 1;
    localparam logic [BW-1:0] LAST_BIT = BW'(N - 1);

    state_t         state_q;
    state_t         state_d;
    logic           tick;
    logic           restart;
    logic [BW-1:0]  bit_cnt;
    logic [N-1:0]   out_sr;
    logic [N-1:0]   out_sr_d;
    logic [N-1:0]   in_sr;
    logic [N-1:0]   in_sr_d;
    logic           din_smp;
    logic           enter_load;
    logic           enter_latch;
    logic           shift_exit;

    reflet_shift_io_divider #(
        .CLK_DIV (CLK_DIV)
    ) u_divider (
        .clk     (clk),
        .reset   (reset),
        .restart (restart),
        .tick    (tick)
    );

    assign restart     = (state_d != state_q);
    assign enter_load  = (state_d == LOAD)  && (state_q != LOAD);
    assign enter_latch = (state_d == LATCH) && (state_q != LATCH);
    assign shift_exit  = (state_q == SHIFT_HI) && tick;

    // State register
    always_ff @(posedge clk) begin
        if (reset) begin
            state_q <= IDLE;
        end else begin
            state_q <= state_d;
        end
    end

    // Next-state logic: every non-IDLE phase ends on the divider tick
    always_comb begin
        state_d = state_q;
        case (state_q)
            IDLE:     if (enable) state_d = LOAD;
            LOAD:     if (tick)   state_d = SHIFT_LO;
            SHIFT_LO: if (tick)   state_d = SHIFT_HI;
            SHIFT_HI: if (tick)   state_d = (bit_cnt == LAST_BIT) ? LATCH : SHIFT_LO;
            LATCH:    if (tick)   state_d = enable ? LOAD : IDLE;
            default:              state_d = IDLE;
        endcase
    end

    // Status outputs decoded from the current state
    always_comb begin
        busy         = (state_q != IDLE);
        refresh_done = (state_q == LATCH) && tick;
    end

    // Next shift-register contents: snapshot on LOAD entry, shift on SHIFT_HI exit
    always_comb begin
        out_sr_d = out_sr;
        in_sr_d  = in_sr;
        if (enter_load) begin
            out_sr_d = gpo_in;
        end else if (shift_exit) begin
            out_sr_d   = out_sr << 1;
            in_sr_d    = in_sr << 1;
            in_sr_d[0] = din_smp;
        end
    end

    // Datapath registers, bit counter and captured inputs
    always_ff @(posedge clk) begin
        if (reset) begin
            out_sr  <= '0;
            in_sr   <= '0;
            din_smp <= 1'b0;
            bit_cnt <= '0;
            gpi_out <= '0;
        end else begin
            out_sr <= out_sr_d;
            in_sr  <= in_sr_d;
            if ((state_q == SHIFT_LO) && tick) begin
                din_smp <= sr_din;
            end
            if (enter_load) begin
                bit_cnt <= '0;
            end else if (shift_exit && (state_d == SHIFT_LO)) begin
                bit_cnt <= bit_cnt + 1'b1;
            end
            if (enter_latch) begin
                gpi_out <= in_sr_d;
            end
        end
    end

    // Chain control pins registered from the next state so they are glitch-free
    // and line up exactly with the state they belong to
    always_ff @(posedge clk) begin
        if (reset) begin
            sr_clk    <= 1'b0;
            sr_latch  <= 1'b0;
            sr_load_n <= 1'b1;
            sr_dout   <= 1'b0;
        end else begin
            sr_clk    <= (state_d == SHIFT_HI);
            sr_latch  <= (state_d == LATCH);
            sr_load_n <= (state_d != LOAD);
            sr_dout   <= ((state_d == SHIFT_LO) || (state_d == SHIFT_HI)) ? out_sr_d[N-1] : 1'b0;
        end
    end

endmodule
